// File: rtl/rom_fetch_arbiter.sv
// Serialises two toggle-handshake tile-layer ROM fetchers onto one SDRAM read channel.
// Optional `ROM_ARB_FIXED_PRIO_EN: layer A always wins contention instead of round-robin.
module rom_fetch_arbiter #(
  parameter int ADDR_W = 21,
  parameter int SDR_AW = 25,
  parameter logic [SDR_AW-1:0] BASE_A = 25'h0100000,
  parameter logic [SDR_AW-1:0] BASE_B = 25'h0180000
) (
  input  logic              CLK_32M,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_req,
  output logic              a_ack,
  output logic [31:0]       a_data,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_req,
  output logic              b_ack,
  output logic [31:0]       b_data,
  output logic [SDR_AW-1:0] sdr_addr,
  output logic              sdr_req,
  input  logic              sdr_ack,
  input  logic [31:0]       sdr_data
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic               a_pend, b_pend, sdr_busy;
  logic               pick_b;
  logic               grant_q;   // 0 = A, 1 = B
  logic               last_q;    // client served most recently
  logic [ADDR_W-1:0]  addr_q;
  logic               grant_en, issue_en, done_en;

  assign a_pend   = a_req ^ a_ack;
  assign b_pend   = b_req ^ b_ack;
  assign sdr_busy = sdr_req ^ sdr_ack;

`ifdef ROM_ARB_FIXED_PRIO_EN
  assign pick_b = b_pend & ~a_pend;
`else
  // B wins a tie only when A was the last client served
  assign pick_b = b_pend & (~a_pend | ~last_q);
`endif

  always_ff @(posedge CLK_32M) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (a_pend | b_pend) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (!sdr_busy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_en = (state_q == S_IDLE) && (a_pend || b_pend);
    issue_en = (state_q == S_ISSUE);
    done_en  = (state_q == S_WAIT) && !sdr_busy;
  end

  // grant / issue / complete
  always_ff @(posedge CLK_32M) begin
    if (RESET) begin
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      sdr_req  <= 1'b0;
      sdr_addr <= '0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      a_data   <= '0;
      b_data   <= '0;
    end else begin
      if (grant_en) grant_q <= pick_b;
      if (issue_en) begin
        sdr_addr <= (grant_q ? BASE_B : BASE_A) + SDR_AW'(addr_q);
        sdr_req  <= ~sdr_req;
      end
      if (done_en) begin
        last_q <= grant_q;
        if (grant_q) begin
          b_data <= sdr_data;
          b_ack  <= ~b_ack;
        end else begin
          a_data <= sdr_data;
          a_ack  <= ~a_ack;
        end
      end
    end
  end

  always_ff @(posedge CLK_32M) begin
    if (grant_en) addr_q <= pick_b ? b_addr : a_addr;
  end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Self-checking bench for rom_fetch_arbiter: directed table, corner sequences, randomized traffic.
`timescale 1ns/1ps
module tb_rom_fetch_arbiter;

  localparam logic [24:0] BA = 25'h0100000;
  localparam logic [24:0] BB = 25'h0180000;

  logic        CLK_32M = 1'b0;
  logic        RESET = 1'b1;
  logic [20:0] a_addr = '0, b_addr = '0;
  logic        a_req = 1'b0, b_req = 1'b0;
  logic        a_ack, b_ack, sdr_req;
  logic [31:0] a_data, b_data;
  logic [24:0] sdr_addr;
  logic        sdr_ack = 1'b0;
  logic [31:0] sdr_data = '0;

  rom_fetch_arbiter dut (
    .CLK_32M(CLK_32M), .RESET(RESET),
    .a_addr(a_addr), .a_req(a_req), .a_ack(a_ack), .a_data(a_data),
    .b_addr(b_addr), .b_req(b_req), .b_ack(b_ack), .b_data(b_data),
    .sdr_addr(sdr_addr), .sdr_req(sdr_req), .sdr_ack(sdr_ack), .sdr_data(sdr_data)
  );

  always #15.625 CLK_32M = ~CLK_32M;

  int nvec = 0;
  int nerr = 0;
  int ack_delay = 0;
  logic fixed_en = 1'b0;
  logic [31:0] fixed_data = '0;
  logic [24:0] issues[$];

  function automatic logic [31:0] rom_word(input logic [24:0] ad);
    return {7'h35, ad} ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SDRAM controller model: logs each new request, answers after ack_delay cycles
  initial begin : responder
    logic prev_req;
    int cnt;
    prev_req = 1'b0;
    cnt = 0;
    forever begin
      @(negedge CLK_32M);
      if (RESET) begin
        sdr_ack = 1'b0;
        prev_req = 1'b0;
        cnt = 0;
      end else begin
        if (sdr_req != prev_req) begin
          chk("req_while_busy", {31'b0, prev_req != sdr_ack}, 32'd0);
          issues.push_back(sdr_addr);
          prev_req = sdr_req;
          cnt = 0;
        end
        if (sdr_req != sdr_ack) begin
          if (cnt >= ack_delay) begin
            chk("addr_stable", {7'b0, sdr_addr}, {7'b0, issues[$]});
            sdr_data = fixed_en ? fixed_data : rom_word(sdr_addr);
            sdr_ack = sdr_req;
            cnt = 0;
          end else cnt++;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge CLK_32M);
    RESET = 1'b1;
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (2) @(negedge CLK_32M);
    RESET = 1'b0;
    issues.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((a_req != a_ack || b_req != b_ack) && n < budget) begin
      @(negedge CLK_32M);
      n++;
    end
    if (a_req != a_ack || b_req != b_ack) begin
      nvec++;
      nerr++;
      $display("FAIL timeout: clients still pending after %0d cycles", budget);
    end
  endtask

  task automatic fetch_a(input logic [20:0] ad);
    @(negedge CLK_32M);
    a_addr = ad;
    a_req = ~a_req;
    wait_idle(200);
    chk("pre_a_data", a_data, rom_word(BA + 25'(ad)));
  endtask

  typedef struct {
    logic        pre_a;
    logic [20:0] a;
    logic [20:0] b;
    logic [24:0] first;
    logic [24:0] second;
  } row_t;

  row_t rows[4];

  initial begin
    int n;
    logic [24:0] exp_a, exp_b;
    logic a_out, b_out;
    logic old_ack;

    rows[0] = '{1'b0, 21'h10, 21'h20, 25'h0100010, 25'h0180020};
    rows[1] = '{1'b0, 21'h30, 21'h44, 25'h0100030, 25'h0180044};
`ifdef ROM_ARB_FIXED_PRIO_EN
    rows[2] = '{1'b1, 21'h50, 21'h60, 25'h0100050, 25'h0180060};
    rows[3] = '{1'b1, 21'h1FFFFF, 21'h1FFFFF, 25'h02FFFFF, 25'h037FFFF};
`else
    rows[2] = '{1'b1, 21'h50, 21'h60, 25'h0180060, 25'h0100050};
    rows[3] = '{1'b1, 21'h1FFFFF, 21'h1FFFFF, 25'h037FFFF, 25'h02FFFFF};
`endif

    do_reset();
    @(negedge CLK_32M);
    chk("rst_a_ack", {31'b0, a_ack}, 32'd0);
    chk("rst_b_ack", {31'b0, b_ack}, 32'd0);
    chk("rst_sdr_req", {31'b0, sdr_req}, 32'd0);
    chk("rst_a_data", a_data, 32'd0);
    chk("rst_b_data", b_data, 32'd0);
    chk("rst_sdr_addr", {7'b0, sdr_addr}, 32'd0);

    // single fetch with minimum latency
    fixed_en = 1'b1;
    fixed_data = 32'hDEADBEEF;
    ack_delay = 0;
    a_addr = 21'h001234;
    a_req = 1'b1;
    n = 0;
    while (a_ack != a_req && n < 50) begin
      @(negedge CLK_32M);
      n++;
    end
    chk("single_latency", n, 32'd3);
    chk("single_sdr_addr", {7'b0, sdr_addr}, 32'h0101234);
    chk("single_a_data", a_data, 32'hDEADBEEF);
    chk("single_b_ack", {31'b0, b_ack}, 32'd0);
    chk("single_b_data", b_data, 32'd0);
    fixed_en = 1'b0;

    // contention table
    for (int i = 0; i < 4; i++) begin
      do_reset();
      if (rows[i].pre_a) fetch_a(21'h7);
      issues.delete();
      @(negedge CLK_32M);
      a_addr = rows[i].a;
      b_addr = rows[i].b;
      a_req = ~a_req;
      b_req = ~b_req;
      wait_idle(200);
      chk($sformatf("row%0d_count", i), issues.size(), 32'd2);
      if (issues.size() == 2) begin
        chk($sformatf("row%0d_first", i), {7'b0, issues[0]}, {7'b0, rows[i].first});
        chk($sformatf("row%0d_second", i), {7'b0, issues[1]}, {7'b0, rows[i].second});
      end
      chk($sformatf("row%0d_a_data", i), a_data, rom_word(BA + 25'(rows[i].a)));
      chk($sformatf("row%0d_b_data", i), b_data, rom_word(BB + 25'(rows[i].b)));
    end

    // address change after grant must not affect the in-flight fetch
    issues.delete();
    ack_delay = 3;
    @(negedge CLK_32M);
    a_addr = 21'h40;
    a_req = ~a_req;
    @(negedge CLK_32M);
    a_addr = 21'h80;
    wait_idle(200);
    chk("addrchg_sdr_addr", {7'b0, issues[0]}, 32'h0100040);
    chk("addrchg_a_data", a_data, rom_word(25'h0100040));

    // slow SDRAM
    issues.delete();
    ack_delay = 20;
    @(negedge CLK_32M);
    a_addr = 21'h1AB;
    old_ack = a_ack;
    a_req = ~a_req;
    repeat (12) @(negedge CLK_32M);
    chk("slow_no_early_ack", {31'b0, a_ack}, {31'b0, old_ack});
    n = 0;
    while (a_ack != a_req && n < 100) begin
      @(negedge CLK_32M);
      n++;
    end
    chk("slow_ack_done", {31'b0, a_ack}, {31'b0, a_req});
    chk("slow_data_with_ack", a_data, rom_word(25'h01001AB));
    chk("slow_one_req", issues.size(), 32'd1);

    // reset during WAIT
    ack_delay = 20;
    @(negedge CLK_32M);
    b_addr = 21'h55;
    b_req = ~b_req;
    repeat (5) @(negedge CLK_32M);
    do_reset();
    @(negedge CLK_32M);
    chk("midrst_b_ack", {31'b0, b_ack}, 32'd0);
    chk("midrst_a_ack", {31'b0, a_ack}, 32'd0);
    chk("midrst_sdr_req", {31'b0, sdr_req}, 32'd0);
    chk("midrst_a_data", a_data, 32'd0);
    chk("midrst_b_data", b_data, 32'd0);
    ack_delay = 0;
    b_addr = 21'h99;
    b_req = 1'b1;
    n = 0;
    while (b_ack != b_req && n < 50) begin
      @(negedge CLK_32M);
      n++;
    end
    chk("midrst_next_latency", n, 32'd3);
    chk("midrst_next_data", b_data, rom_word(25'h0180099));

    // randomized traffic against a per-client outstanding-request model
    a_out = 1'b0;
    b_out = 1'b0;
    exp_a = '0;
    exp_b = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK_32M);
      ack_delay = $urandom_range(0, 3);
      if (a_out && a_req == a_ack) begin
        chk("rand_a_data", a_data, rom_word(exp_a));
        a_out = 1'b0;
      end
      if (b_out && b_req == b_ack) begin
        chk("rand_b_data", b_data, rom_word(exp_b));
        b_out = 1'b0;
      end
      if (!a_out && $urandom_range(0, 3) == 0) begin
        a_addr = 21'($urandom);
        exp_a = BA + 25'(a_addr);
        a_req = ~a_req;
        a_out = 1'b1;
      end
      if (!b_out && $urandom_range(0, 3) == 0) begin
        b_addr = 21'($urandom);
        exp_b = BB + 25'(b_addr);
        b_req = ~b_req;
        b_out = 1'b1;
      end
    end
    wait_idle(200);
    if (a_out) chk("rand_a_tail", a_data, rom_word(exp_a));
    if (b_out) chk("rand_b_tail", b_data, rom_word(exp_b));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
